state_ntt_polyvec_reduce: RTL and testbench
===========================================

Name: state_ntt_polyvec_reduce

Overview:
Parametrised in-place coefficient reduction engine for the NTT/polynomial datapath. It streams one coefficient per cycle from a synchronous coefficient RAM holding up to KYBER_K contiguous polynomials. Each coefficient goes through a selectable reduction: full Barrett, conditional subtract-q, or conditional add-q. Results are written back to the same addresses. It generalises the single-polynomial Barrett pass with runtime polynomial count, mode select, configurable RAM read latency and a start/busy/done handshake.

Parameters:
KYBER_K, 2, max polynomials per pass; RAM depth = KYBER_K*KYBER_N
KYBER_N, 256, coefficients per polynomial
KYBER_Q, 3329, modulus
DATA_W, 16, coefficient width (two's complement)
RD_LAT, 1, coefficient RAM read latency in cycles (1..3)
AW, $clog2(KYBER_K*KYBER_N), address width (derived, localparam)

Ports:
clk  input  1  clock; all logic rising-edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
mode  input  2  0=BARRETT, 1=CSUBQ, 2=CADDQ, 3=COPY; latched at start
num_polys  input  $clog2(KYBER_K+1)  polynomials to process; latched at start
Coef_REN  output  1  RAM read enable
Coef_RAd  output  AW  RAM read address
Coef_RData  input  DATA_W  RAM read data, valid RD_LAT cycles after address
Coef_WEN  output  1  RAM write enable
Coef_WAd  output  AW  RAM write address
Coef_WData  output  DATA_W  RAM write data
busy  output  1  high from first read cycle through done cycle
done  output  1  one-cycle pulse at end of pass

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0. Pipeline valids cleared. No write is emitted after reset releases.
- States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- Latching: cycle 0 = edge sampling start=1 in IDLE. mode and num_polys are latched at that edge. L = min(num_polys, KYBER_K)*KYBER_N.
- num_polys=0: IDLE -> DONE directly. busy=done=1 in cycle 1. No REN/WEN.
- RUN: address a (0..L-1) is driven with Coef_REN=1 in cycle 1+a. Address increments by 1 each cycle with no gaps. After a=L-1 the state goes to DRAIN.
- Compute pipeline: exactly 2 register stages after Coef_RData is valid. Write for address a has Coef_WEN=1 and Coef_WAd=a in cycle a+RD_LAT+3. WEN is high for exactly L consecutive cycles.
- In-place safety: writes trail reads, so no read-after-write hazard exists.
- DRAIN lasts until the last write cycle, L+RD_LAT+2. DONE is the following cycle, L+RD_LAT+3, with done=1 and busy=1. IDLE follows.
- Idle outputs: REN=WEN=0. RAd/WAd/WData are held at 0, never X.
- start is ignored when not in IDLE, including the DONE cycle. mode/num_polys changes mid-pass have no effect.
- Arithmetic: the input x is signed DATA_W. Output is always in [0, KYBER_Q-1] except in COPY mode.
  - BARRETT: x mod Q, canonical, for all x in [-2^15, 2^15-1]. Use v = round(2^26/Q) = 20159, t = (v*x + 2^25) >>> 26, r = x - t*Q, then add Q if r<0. Internal products are at least 32-bit signed.
  - CSUBQ: input defined for [0, 2Q-1]. Output x-Q if x>=Q, else x.
  - CADDQ: input defined for [-Q, Q-1]. Output x+Q if x<0, else x.
  - COPY: output = x unchanged. Reserved for test/debug.
- Out-of-range inputs in CSUBQ/CADDQ: single conditional op applied, no error flag.

Test Plan:
- BARRETT, num_polys=1, RAM preloaded with -32768, 32767, 3329, -1, 0 at addr 0..4 -> RAM reads 522, 2806, 0, 3328, 0. All 256 words equal the software x mod 3329.
- CSUBQ, num_polys=2, coefficients {3328, 3329, 6657, 0} repeated -> {3328, 0, 3328, 0}. Addresses 0..511 are all written exactly once.
- CADDQ with {-3329, -1, 5, 3328} -> {0, 3328, 5, 3328}.
- Timing, RD_LAT=1, L=512, start at cycle 0 -> REN cycles 1..512, WEN cycles 4..515 with WAd=0 at cycle 4, done single pulse at 516, busy 1..516. Repeat with RD_LAT=3: first write at 6, done at 518.
- start pulsed at cycle 100 and at the done cycle -> ignored, no second pass. num_polys=0 -> done at cycle 1, no accesses. num_polys=3 with K=2 -> clamped to 512 writes.
- reset_n low at cycle 200 mid-RUN -> all outputs 0 asynchronously. After release: IDLE, no WEN, next start runs a full correct pass.

Source files
------------

// File: rtl/state_ntt_polyvec_reduce.sv
// In-place coefficient reduction over up to KYBER_K contiguous polynomials.
// Streams one coefficient per cycle: read -> RD_LAT -> 2 compute stages -> write-back.
module state_ntt_polyvec_reduce #(
  parameter int KYBER_K = 2,
  parameter int KYBER_N = 256,
  parameter int KYBER_Q = 3329,
  parameter int DATA_W  = 16,
  parameter int RD_LAT  = 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [1:0]                           mode,
  input  logic [$clog2(KYBER_K+1)-1:0]         num_polys,
  output logic                                 Coef_REN,
  output logic [$clog2(KYBER_K*KYBER_N)-1:0]   Coef_RAd,
  input  logic [DATA_W-1:0]                    Coef_RData,
  output logic                                 Coef_WEN,
  output logic [$clog2(KYBER_K*KYBER_N)-1:0]   Coef_WAd,
  output logic [DATA_W-1:0]                    Coef_WData,
  output logic                                 busy,
  output logic                                 done
);

  localparam int AW  = $clog2(KYBER_K*KYBER_N);
  localparam int NPW = $clog2(KYBER_K+1);
  localparam int CW  = AW + 1;

  localparam logic signed [31:0] BAR_V   = 32'sd20159;
  localparam logic signed [31:0] BAR_RND = 32'sd33554432;
  localparam logic signed [31:0] QS      = KYBER_Q;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {MODE_BARRETT, MODE_CSUBQ, MODE_CADDQ, MODE_COPY} mode_t;

  state_t         state;
  mode_t          mode_q;
  logic [AW-1:0]  last_q;

  logic [NPW-1:0] np_clamped;
  logic [CW-1:0]  len_next;

  logic [RD_LAT-1:0] rv_pipe;
  logic [AW-1:0]     ra_pipe [RD_LAT];

  logic               s1_valid;
  logic [AW-1:0]      s1_addr;
  logic signed [31:0] s1_x;
  logic signed [31:0] s1_t;

  logic signed [31:0] x_in;
  logic signed [31:0] prod;
  logic signed [31:0] t_in;
  logic signed [31:0] r_bar;
  logic signed [31:0] res;

  // Requests beyond the RAM capacity are clamped to KYBER_K polynomials.
  always_comb begin
    np_clamped = num_polys;
    if (num_polys > NPW'(KYBER_K))
      np_clamped = NPW'(KYBER_K);
    len_next = CW'(np_clamped) * CW'(KYBER_N);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      mode_q   <= MODE_BARRETT;
      last_q   <= '0;
      Coef_REN <= 1'b0;
      Coef_RAd <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode_t'(mode);
            busy   <= 1'b1;
            if (len_next == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_RUN;
              last_q   <= AW'(len_next - 1'b1);
              Coef_REN <= 1'b1;
              Coef_RAd <= '0;
            end
          end
        end
        S_RUN: begin
          if (Coef_RAd == last_q) begin
            Coef_REN <= 1'b0;
            Coef_RAd <= '0;
            state    <= S_DRAIN;
          end else begin
            Coef_RAd <= Coef_RAd + 1'b1;
          end
        end
        // Leave DRAIN on the cycle the final address is being written.
        S_DRAIN: begin
          if (Coef_WEN && (Coef_WAd == last_q)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tracks which read requests have data arriving from the RAM this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rv_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++)
        ra_pipe[i] <= '0;
    end else begin
      rv_pipe[0] <= Coef_REN;
      ra_pipe[0] <= Coef_RAd;
      for (int i = 1; i < RD_LAT; i++) begin
        rv_pipe[i] <= rv_pipe[i-1];
        ra_pipe[i] <= ra_pipe[i-1];
      end
    end
  end

  // Barrett quotient estimate, t = round(x / Q), computed on the raw RAM data.
  always_comb begin
    x_in = {{(32-DATA_W){Coef_RData[DATA_W-1]}}, Coef_RData};
    prod = (x_in * BAR_V) + BAR_RND;
    t_in = prod >>> 26;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_x     <= '0;
      s1_t     <= '0;
    end else begin
      s1_valid <= rv_pipe[RD_LAT-1];
      s1_addr  <= ra_pipe[RD_LAT-1];
      s1_x     <= x_in;
      s1_t     <= t_in;
    end
  end

  always_comb begin
    r_bar = s1_x - (s1_t * QS);
    res   = s1_x;
    case (mode_q)
      MODE_BARRETT: res = (r_bar < 0) ? (r_bar + QS) : r_bar;
      MODE_CSUBQ:   res = (s1_x >= QS) ? (s1_x - QS) : s1_x;
      MODE_CADDQ:   res = (s1_x < 0) ? (s1_x + QS) : s1_x;
      default:      res = s1_x;
    endcase
  end

  // Write port is forced to zero between valid results so idle outputs stay defined.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Coef_WEN   <= 1'b0;
      Coef_WAd   <= '0;
      Coef_WData <= '0;
    end else begin
      Coef_WEN   <= s1_valid;
      Coef_WAd   <= s1_valid ? s1_addr : '0;
      Coef_WData <= s1_valid ? DATA_W'(res) : '0;
    end
  end

endmodule

// File: tb/tb_state_ntt_polyvec_reduce.sv
// Scoreboard bench for state_ntt_polyvec_reduce: RAM model, expected-write queue,
// negedge monitor, directed passes with hand-computed values and cycle timing.
module tb_state_ntt_polyvec_reduce;

  localparam int K   = 2;
  localparam int N   = 256;
  localparam int Q   = 3329;
  localparam int DW  = 16;
  localparam int RDL = 1;
  localparam int AW  = $clog2(K*N);
  localparam int NPW = $clog2(K+1);

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [1:0]     mode;
  logic [NPW-1:0] num_polys;
  logic           ren;
  logic [AW-1:0]  rad;
  logic [DW-1:0]  rdata;
  logic           wen;
  logic [AW-1:0]  wad;
  logic [DW-1:0]  wdata;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  state_ntt_polyvec_reduce #(
    .KYBER_K(K), .KYBER_N(N), .KYBER_Q(Q), .DATA_W(DW), .RD_LAT(RDL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .num_polys(num_polys),
    .Coef_REN(ren), .Coef_RAd(rad), .Coef_RData(rdata),
    .Coef_WEN(wen), .Coef_WAd(wad), .Coef_WData(wdata),
    .busy(busy), .done(done)
  );

  // Synchronous RAM with RDL-cycle read latency.
  logic [DW-1:0] mem [K*N];
  logic [DW-1:0] rd_pipe [RDL];
  always @(posedge clk) begin
    if (wen) mem[wad] <= wdata;
    rd_pipe[0] <= ren ? mem[rad] : '0;
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rdata = rd_pipe[RDL-1];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t expq[$];

  int total = 0;
  int bad   = 0;
  int edge_count = 0;
  int base = 0;
  int ren_cnt, wen_cnt, done_cnt, busy_cnt;
  int first_ren, last_ren, first_wen, last_wen, done_cyc, first_busy, last_busy, first_wad;

  always @(posedge clk) edge_count <= edge_count + 1;

  function automatic logic [DW-1:0] expectOf(input logic [1:0] m, input logic [DW-1:0] raw);
    int x;
    int r;
    x = $signed(raw);
    case (m)
      2'd0:    r = ((x % Q) + Q) % Q;
      2'd1:    r = (x >= Q) ? x - Q : x;
      2'd2:    r = (x < 0) ? x + Q : x;
      default: r = x;
    endcase
    return DW'(r);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
    end
  endtask

  task automatic clearStats();
    ren_cnt = 0; wen_cnt = 0; done_cnt = 0; busy_cnt = 0;
    first_ren = -1; last_ren = -1; first_wen = -1; last_wen = -1;
    done_cyc = -1; first_busy = -1; last_busy = -1; first_wad = -1;
  endtask

  task automatic pushExpected(input logic [1:0] m, input int np);
    int len;
    wr_t w;
    len = ((np > K) ? K : np) * N;
    for (int a = 0; a < len; a++) begin
      w.a = AW'(a);
      w.d = expectOf(m, mem[a]);
      expq.push_back(w);
    end
  endtask

  // Issues one start pulse; mode/num_polys are scrambled right after the sampling edge.
  task automatic applyStimulus(input logic [1:0] m, input int np);
    clearStats();
    pushExpected(m, np);
    @(negedge clk);
    mode = m;
    num_polys = NPW'(np);
    start = 1'b1;
    @(posedge clk);
    #1;
    base = edge_count;
    start = 1'b0;
    mode = 2'd3;
    num_polys = '0;
  endtask

  task automatic waitDone(input int bound);
    int n;
    n = 0;
    while (done_cnt == 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == 0) checkOutput("done_timeout", 0, 1);
    repeat (12) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every write and records handshake timing.
  initial begin : monitor
    int rel;
    wr_t e;
    forever begin
      @(negedge clk);
      rel = edge_count - base + 1;
      if (ren) begin
        total++;
        if (rad !== AW'(ren_cnt)) begin
          bad++;
          $display("[TB] FAIL rd_addr got=%0d want=%0d", rad, ren_cnt);
        end
        if (ren_cnt == 0) first_ren = rel;
        last_ren = rel;
        ren_cnt++;
      end
      if (wen) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_write addr=%0d data=%0d want=none", wad, wdata);
        end else begin
          e = expq.pop_front();
          if (wad !== e.a || wdata !== e.d) begin
            bad++;
            $display("[TB] FAIL write got=%0d:%0d want=%0d:%0d", wad, wdata, e.a, e.d);
          end
        end
        if (wen_cnt == 0) begin
          first_wen = rel;
          first_wad = int'(wad);
        end
        last_wen = rel;
        wen_cnt++;
      end
      if (busy) begin
        if (busy_cnt == 0) first_busy = rel;
        last_busy = rel;
        busy_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = rel;
      end
    end
  end

  initial begin
    int n;
    logic [DW-1:0] pat [4];
    reset_n = 1'b0;
    start = 1'b0;
    mode = 2'd0;
    num_polys = '0;
    clearStats();
    repeat (3) @(negedge clk);
    checkOutput("rst_ren", int'(ren), 0);
    checkOutput("rst_wen", int'(wen), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_rad", int'(rad), 0);
    checkOutput("rst_wdata", int'(wdata), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_ren", int'(ren), 0);

    // BARRETT, one polynomial, extremes first.
    mem[0] <= 16'h8000;
    mem[1] <= 16'h7FFF;
    mem[2] <= 16'd3329;
    mem[3] <= 16'hFFFF;
    mem[4] <= 16'd0;
    for (int a = 5; a < N; a++) mem[a] <= DW'(a*257 - 32768);
    for (int a = N; a < K*N; a++) mem[a] <= 16'h1234;
    @(negedge clk);
    applyStimulus(2'd0, 1);
    waitDone(2000);
    checkOutput("bar_m0", int'(mem[0]), 522);
    checkOutput("bar_m1", int'(mem[1]), 2806);
    checkOutput("bar_m2", int'(mem[2]), 0);
    checkOutput("bar_m3", int'(mem[3]), 3328);
    checkOutput("bar_m4", int'(mem[4]), 0);
    checkOutput("bar_untouched", int'(mem[300]), 16'h1234);
    checkOutput("bar_wen_cnt", wen_cnt, 256);
    checkOutput("bar_done_cyc", done_cyc, 256 + RDL + 3);
    checkOutput("bar_q_empty", expq.size(), 0);

    // CSUBQ, two polynomials, plus stray start pulses mid-pass and at done.
    pat[0] = 16'd3328; pat[1] = 16'd3329; pat[2] = 16'd6657; pat[3] = 16'd0;
    for (int a = 0; a < K*N; a++) mem[a] <= pat[a % 4];
    @(negedge clk);
    applyStimulus(2'd1, 2);
    repeat (98) @(negedge clk);
    start = 1'b1; mode = 2'd0; num_polys = NPW'(1);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 2000);
    if (done) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end else begin
      checkOutput("csub_done_seen", 0, 1);
    end
    waitDone(2000);
    repeat (10) @(negedge clk);
    checkOutput("csub_m0", int'(mem[0]), 3328);
    checkOutput("csub_m1", int'(mem[1]), 0);
    checkOutput("csub_m2", int'(mem[2]), 3328);
    checkOutput("csub_m3", int'(mem[3]), 0);
    checkOutput("csub_m510", int'(mem[510]), 3328);
    checkOutput("t_first_ren", first_ren, 1);
    checkOutput("t_last_ren", last_ren, 512);
    checkOutput("t_ren_cnt", ren_cnt, 512);
    checkOutput("t_first_wen", first_wen, RDL + 3);
    checkOutput("t_first_wad", first_wad, 0);
    checkOutput("t_last_wen", last_wen, 512 + RDL + 2);
    checkOutput("t_wen_cnt", wen_cnt, 512);
    checkOutput("t_done_cyc", done_cyc, 512 + RDL + 3);
    checkOutput("t_done_cnt", done_cnt, 1);
    checkOutput("t_first_busy", first_busy, 1);
    checkOutput("t_last_busy", last_busy, 512 + RDL + 3);
    checkOutput("t_busy_cnt", busy_cnt, 512 + RDL + 3);
    checkOutput("csub_q_empty", expq.size(), 0);

    // CADDQ with num_polys beyond K: clamped to K polynomials.
    pat[0] = 16'hF2FF; pat[1] = 16'hFFFF; pat[2] = 16'd5; pat[3] = 16'd3328;
    for (int a = 0; a < K*N; a++) mem[a] <= pat[a % 4];
    @(negedge clk);
    applyStimulus(2'd2, 3);
    waitDone(2000);
    checkOutput("cadd_m0", int'(mem[0]), 0);
    checkOutput("cadd_m1", int'(mem[1]), 3328);
    checkOutput("cadd_m2", int'(mem[2]), 5);
    checkOutput("cadd_m3", int'(mem[3]), 3328);
    checkOutput("cadd_m509", int'(mem[509]), 3328);
    checkOutput("cadd_wen_cnt", wen_cnt, 512);
    checkOutput("cadd_done_cyc", done_cyc, 512 + RDL + 3);

    // num_polys = 0: immediate done, no RAM traffic.
    applyStimulus(2'd0, 0);
    waitDone(50);
    checkOutput("np0_done_cyc", done_cyc, 1);
    checkOutput("np0_done_cnt", done_cnt, 1);
    checkOutput("np0_busy_cnt", busy_cnt, 1);
    checkOutput("np0_ren_cnt", ren_cnt, 0);
    checkOutput("np0_wen_cnt", wen_cnt, 0);

    // Asynchronous reset in the middle of a pass, then a full clean pass.
    for (int a = 0; a < K*N; a++) mem[a] <= DW'(a*131 - 30000);
    @(negedge clk);
    applyStimulus(2'd0, 2);
    repeat (198) @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_ren", int'(ren), 0);
    checkOutput("arst_wen", int'(wen), 0);
    checkOutput("arst_busy", int'(busy), 0);
    checkOutput("arst_rad", int'(rad), 0);
    checkOutput("arst_wad", int'(wad), 0);
    checkOutput("arst_wdata", int'(wdata), 0);
    expq.delete();
    repeat (3) @(negedge clk);
    clearStats();
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("post_rst_wen", wen_cnt, 0);
    checkOutput("post_rst_ren", ren_cnt, 0);
    checkOutput("post_rst_busy", busy_cnt, 0);
    applyStimulus(2'd0, 2);
    waitDone(2000);
    checkOutput("rerun_m0", int'(mem[0]), 3290);
    checkOutput("rerun_m511", int'(mem[511]), 1366);
    checkOutput("rerun_wen_cnt", wen_cnt, 512);
    checkOutput("rerun_done_cyc", done_cyc, 512 + RDL + 3);
    checkOutput("rerun_q_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
